// File: rtl/rtsnoc_to_wishbone_master_if.sv
// Bus bundle for the NoC-to-Wishbone target endpoint: Wishbone master side,
// router local port (TX/RX) and the peripheral interrupt line.
interface rtsnoc_to_wishbone_master_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int BUS_W  = 42
);
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic [ADDR_W-1:0] wb_adr_o;
  logic [3:0]        wb_sel_o;
  logic              wb_we_o;
  logic [DATA_W-1:0] wb_dat_o;
  logic [DATA_W-1:0] wb_dat_i;
  logic              wb_ack_i;
  logic              int_i;
  logic [BUS_W-1:0]  noc_din_o;
  logic              noc_wr_o;
  logic              noc_rd_o;
  logic [BUS_W-1:0]  noc_dout_i;
  logic              noc_wait_i;
  logic              noc_nd_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, int_i,
    output noc_din_o, noc_wr_o, noc_rd_o,
    input  noc_dout_i, noc_wait_i, noc_nd_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, int_i,
    input  noc_din_o, noc_wr_o, noc_rd_o,
    output noc_dout_i, noc_wait_i, noc_nd_i
  );
endinterface

// File: rtl/rtsnoc_to_wishbone_master.sv
// Target-side RTSNoC endpoint: executes WRITE/READ command packets as single
// Wishbone master cycles, returns read data and forwards the peripheral IRQ.
module rtsnoc_to_wishbone_master #(
  parameter int WB_ADDR_WIDTH     = 6,
  parameter int WB_NOC_DATA_WIDTH = 32,
  parameter int NOC_LOCAL_ADR     = 0,
  parameter int NOC_X             = 0,
  parameter int NOC_Y             = 0,
  parameter int NOC_LOCAL_ADR_INT = 0,
  parameter int NOC_X_INT         = 0,
  parameter int NOC_Y_INT         = 0,
  parameter int SOC_SIZE_X        = 1,
  parameter int SOC_SIZE_Y        = 1,
  parameter int WB_TIMEOUT        = 255
) (
  input logic clk_i,
  input logic rstn_i,
  rtsnoc_to_wishbone_master_if.master bus
);
  localparam int DW           = WB_NOC_DATA_WIDTH;
  localparam int HW           = SOC_SIZE_X + SOC_SIZE_Y + 3;
  localparam int NOC_BUS_SIZE = DW + 2 * HW;

  localparam logic [2:0] T_WRITE = 3'd0;
  localparam logic [2:0] T_READ  = 3'd1;
  localparam logic [2:0] T_INT   = 3'd2;
  localparam logic [2:0] T_ERR   = 3'd3;

  localparam logic [HW-1:0] ORIG_HDR =
    {SOC_SIZE_X'(NOC_X), SOC_SIZE_Y'(NOC_Y), 3'(NOC_LOCAL_ADR)};
  localparam logic [HW-1:0] INT_HDR =
    {SOC_SIZE_X'(NOC_X_INT), SOC_SIZE_Y'(NOC_Y_INT), 3'(NOC_LOCAL_ADR_INT)};
  localparam logic [DW-1:0] INT_WORD = {T_INT, {(DW-3){1'b0}}};
  localparam logic [DW-1:0] ERR_WORD = {T_ERR, {(DW-3){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_WB_WRITE,
    S_WB_READ,
    S_TX_REPLY,
    S_TX_INT
  } state_t;

  state_t                   state_q, state_d;
  logic                     cyc_q, cyc_d;
  logic                     we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DW-1:0]            wdat_q, wdat_d;
  logic [NOC_BUS_SIZE-1:0]  din_q, din_d;
  logic                     wr_q, wr_d;
  logic                     rd_q, rd_d;
  logic [HW-1:0]            dst_q, dst_d;
  logic                     pend_q, pend_d;
  logic                     int_q;
  logic [7:0]               cnt_q, cnt_d;

  logic          rx_take;
  logic [2:0]    rx_type;
  logic [HW-1:0] rx_orig;
  logic          int_edge;
  logic          int_clr;
  logic          tmo_hit;
  logic          tx_done;

  // The cycle after a consume carries noc_rd_o, so noc_nd_i is stale then.
  assign rx_take  = bus.noc_nd_i & ~rd_q;
  assign rx_type  = bus.noc_dout_i[DW-1 -: 3];
  assign rx_orig  = bus.noc_dout_i[NOC_BUS_SIZE-1 -: HW];
  assign int_edge = bus.int_i & ~int_q;
  assign tmo_hit  = ({1'b0, cnt_q} + 9'd1) == 9'(WB_TIMEOUT);
  assign tx_done  = ~wr_q & ~bus.noc_wait_i;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    din_d   = din_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    int_clr = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          din_d   = {ORIG_HDR, INT_HDR, INT_WORD};
          wr_d    = 1'b1;
          state_d = S_TX_INT;
        end else if (rx_take) begin
          rd_d  = 1'b1;
          dst_d = rx_orig;
          if (rx_type == T_WRITE) begin
            adr_d   = bus.noc_dout_i[WB_ADDR_WIDTH-1:0];
            state_d = S_WR_DATA;
          end else if (rx_type == T_READ) begin
            adr_d   = bus.noc_dout_i[WB_ADDR_WIDTH-1:0];
            cyc_d   = 1'b1;
            we_d    = 1'b0;
            cnt_d   = '0;
            state_d = S_WB_READ;
          end
        end
      end
      S_WR_DATA: begin
        if (rx_take) begin
          rd_d    = 1'b1;
          wdat_d  = bus.noc_dout_i[DW-1:0];
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_WB_WRITE;
        end
      end
      S_WB_WRITE: begin
        if (bus.wb_ack_i || tmo_hit) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB_READ: begin
        if (bus.wb_ack_i || tmo_hit) begin
          cyc_d   = 1'b0;
          din_d   = {ORIG_HDR, dst_q, bus.wb_ack_i ? bus.wb_dat_i : ERR_WORD};
          wr_d    = 1'b1;
          state_d = S_TX_REPLY;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_TX_REPLY: begin
        if (tx_done) state_d = S_IDLE;
      end
      S_TX_INT: begin
        if (tx_done) begin
          int_clr = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new edge coinciding with the clear must not be lost.
    pend_d = int_edge | (pend_q & ~int_clr);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      dst_q   <= '0;
      pend_q  <= 1'b0;
      int_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      dst_q   <= dst_d;
      pend_q  <= pend_d;
      int_q   <= bus.int_i;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.wb_cyc_o  = cyc_q;
  assign bus.wb_stb_o  = cyc_q;
  assign bus.wb_we_o   = we_q;
  assign bus.wb_sel_o  = cyc_q ? 4'hF : 4'h0;
  assign bus.wb_adr_o  = adr_q;
  assign bus.wb_dat_o  = wdat_q;
  assign bus.noc_din_o = din_q;
  assign bus.noc_wr_o  = wr_q;
  assign bus.noc_rd_o  = rd_q;

endmodule

// File: tb/tb_rtsnoc_to_wishbone_master.sv
// Bench for rtsnoc_to_wishbone_master: router and Wishbone slave models plus a
// transaction-level scoreboard of expected bus cycles and TX packets.
module tb_rtsnoc_to_wishbone_master;
  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int BW  = DW + 2 * (1 + 1 + 3);
  localparam int TMO = 8;
  localparam logic [4:0] ME      = {1'b1, 1'b1, 3'd3};
  localparam logic [4:0] INT_TGT = {1'b0, 1'b1, 3'd5};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  rtsnoc_to_wishbone_master_if #(.ADDR_W(AW), .DATA_W(DW), .BUS_W(BW)) bus ();

  rtsnoc_to_wishbone_master #(
    .WB_ADDR_WIDTH(AW), .WB_NOC_DATA_WIDTH(DW),
    .NOC_LOCAL_ADR(3), .NOC_X(1), .NOC_Y(1),
    .NOC_LOCAL_ADR_INT(5), .NOC_X_INT(0), .NOC_Y_INT(1),
    .SOC_SIZE_X(1), .SOC_SIZE_Y(1), .WB_TIMEOUT(TMO)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus.master)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [BW-1:0] rxq[$];
  logic [63:0]   obs_wb[$], exp_wb[$], obs_tx[$], exp_tx[$];
  int            lat, waitc;
  int            lat_cnt, rd_cnt, cyc_cnt, sel_err, din_err, rd_viol, k_tx;
  bit            tx_pend, busy_prev;
  logic [BW-1:0] din_hold;

  // One clock of the environment: observe at the falling edge, then drive.
  task automatic tick();
    bit busy;
    @(negedge clk);
    if (bus.noc_rd_o) begin
      rd_cnt++;
      if (busy_prev) rd_viol++;
      if (rxq.size() > 0) void'(rxq.pop_front());
    end
    if (bus.wb_cyc_o) begin
      cyc_cnt++;
      if (bus.wb_sel_o !== 4'hF || bus.wb_stb_o !== 1'b1) sel_err++;
      lat_cnt++;
      bus.wb_ack_i = (lat != 0 && lat_cnt == lat);
      if (bus.wb_ack_i)
        obs_wb.push_back({25'b0, bus.wb_we_o, bus.wb_adr_o, bus.wb_we_o ? bus.wb_dat_o : 32'b0});
    end else begin
      lat_cnt = 0;
      bus.wb_ack_i = 1'b0;
    end
    if (bus.noc_wr_o) begin
      obs_tx.push_back(64'(bus.noc_din_o));
      din_hold = bus.noc_din_o;
      tx_pend = 1'b1;
      k_tx = 0;
    end else if (tx_pend) begin
      k_tx++;
      if (bus.noc_din_o !== din_hold) din_err++;
    end
    busy = bus.wb_cyc_o || tx_pend;
    if (tx_pend) begin
      bus.noc_wait_i = (k_tx == 0) ? (waitc > 0) : (k_tx <= waitc);
      if (k_tx >= 1 && !bus.noc_wait_i) tx_pend = 1'b0;
    end else begin
      bus.noc_wait_i = 1'($urandom_range(0, 1));
    end
    busy_prev = busy;
    bus.noc_nd_i = (rxq.size() > 0);
    bus.noc_dout_i = (rxq.size() > 0) ? rxq[0] : BW'({$urandom(), $urandom()});
  endtask

  task automatic clear_env();
    rxq.delete(); obs_wb.delete(); exp_wb.delete(); obs_tx.delete(); exp_tx.delete();
    tx_pend = 1'b0; busy_prev = 1'b0; lat_cnt = 0;
    bus.wb_ack_i = 1'b0; bus.noc_nd_i = 1'b0; bus.noc_wait_i = 1'b0;
  endtask

  // Sends one command (typ 0 WRITE with data flit, 1 READ, other dropped),
  // optionally a trailing dropped flit and an int_i rise at tick int_at.
  task automatic run_cmd(input string tag, input int typ, input logic [4:0] src,
                         input logic [DW-1:0] cmd_lo, input logic [DW-1:0] wdat,
                         input logic [DW-1:0] rd_val, input int lat_i, input int wait_i,
                         input bit extra, input int int_at);
    logic [DW-1:0] cmd;
    int n_flits, exp_cyc;
    cmd = {3'(typ), cmd_lo[28:0]};
    lat = lat_i; waitc = wait_i; bus.wb_dat_i = rd_val;
    rd_cnt = 0; cyc_cnt = 0; sel_err = 0; din_err = 0; rd_viol = 0;
    rxq.push_back({src, ME, cmd});
    n_flits = 1;
    if (typ == 0) begin rxq.push_back({src, ME, wdat}); n_flits++; end
    if (extra) begin rxq.push_back({src, ME, 32'h8000_0000}); n_flits++; end
    exp_cyc = 0;
    if (typ == 0 || typ == 1) exp_cyc = (lat_i != 0) ? lat_i : TMO;
    if (typ == 0 && lat_i != 0) exp_wb.push_back({25'b0, 1'b1, cmd[AW-1:0], wdat});
    if (typ == 1) begin
      if (lat_i != 0) exp_wb.push_back({25'b0, 1'b0, cmd[AW-1:0], 32'b0});
      exp_tx.push_back(64'({ME, src, (lat_i != 0) ? rd_val : 32'h6000_0000}));
    end
    if (int_at >= 0 && !bus.int_i) exp_tx.push_back(64'({ME, INT_TGT, 32'h4000_0000}));
    for (int t = 0; t < 40; t++) begin
      if (t == int_at) bus.int_i = 1'b1;
      tick();
    end
    check_eq({tag, ".rd_pulses"}, 64'(rd_cnt), 64'(n_flits));
    check_eq({tag, ".cyc_cycles"}, 64'(cyc_cnt), 64'(exp_cyc));
    check_eq({tag, ".sel_stb"}, 64'(sel_err), 64'd0);
    check_eq({tag, ".din_hold"}, 64'(din_err), 64'd0);
    check_eq({tag, ".rd_while_busy"}, 64'(rd_viol), 64'd0);
    check_eq({tag, ".wb_count"}, 64'(obs_wb.size()), 64'(exp_wb.size()));
    while (obs_wb.size() > 0 && exp_wb.size() > 0)
      check_eq({tag, ".wb"}, obs_wb.pop_front(), exp_wb.pop_front());
    check_eq({tag, ".tx_count"}, 64'(obs_tx.size()), 64'(exp_tx.size()));
    while (obs_tx.size() > 0 && exp_tx.size() > 0)
      check_eq({tag, ".tx"}, obs_tx.pop_front(), exp_tx.pop_front());
    obs_wb.delete(); exp_wb.delete(); obs_tx.delete(); exp_tx.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, ".wb"}, 64'({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_adr_o}), 64'd0);
    check_eq({tag, ".wb_dat"}, 64'(bus.wb_dat_o), 64'd0);
    check_eq({tag, ".noc"}, 64'({bus.noc_wr_o, bus.noc_rd_o}), 64'd0);
    check_eq({tag, ".din"}, 64'(bus.noc_din_o), 64'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] src_a;
    src_a = {1'b1, 1'b0, 3'd2};
    bus.int_i = 1'b0; bus.wb_dat_i = '0; bus.noc_dout_i = '0;
    clear_env();
    waitc = 0; lat = 0;
    tick(); tick();
    check_outputs_zero("reset");
    rstn = 1'b1;
    tick();

    run_cmd("write",    0, src_a, 32'h5,  32'hDEAD_BEEF, 32'h0,         3, 0, 1'b0, -1);
    run_cmd("read",     1, src_a, 32'hA,  32'h0,         32'h1234_5678, 2, 0, 1'b0, -1);
    run_cmd("backpr",   1, src_a, 32'hA,  32'h0,         32'h1234_5678, 2, 5, 1'b1, -1);
    run_cmd("rd_tmo",   1, src_a, 32'h3,  32'h0,         32'h5555_5555, 0, 1, 1'b0, -1);
    run_cmd("wr_tmo",   0, src_a, 32'h4,  32'h0BAD_F00D, 32'h0,         0, 0, 1'b0, -1);
    run_cmd("rd_ack_at_tmo", 1, src_a, 32'h3F, 32'h0,    32'hCAFE_0001, TMO, 0, 1'b0, -1);
    run_cmd("unknown",  4, src_a, 32'h0,  32'h0,         32'h0,         1, 0, 1'b0, -1);

    // Reset in the middle of a Wishbone write that is never acknowledged.
    lat = 0; rd_cnt = 0;
    rxq.push_back({src_a, ME, 32'h0000_0011});
    rxq.push_back({src_a, ME, 32'h7777_7777});
    for (int t = 0; t < 6; t++) tick();
    check_eq("rst_mid.cyc_before", 64'(bus.wb_cyc_o), 64'd1);
    rstn = 1'b0;
    tick();
    check_outputs_zero("rst_mid");
    rstn = 1'b1;
    clear_env();
    tick(); tick();
    run_cmd("after_rst", 0, src_a, 32'h21, 32'hA5A5_0F0F, 32'h0, 4, 2, 1'b0, -1);

    run_cmd("int_in_read", 1, src_a, 32'h9, 32'h0, 32'h0000_BEEF, 6, 1, 1'b0, 3);
    run_cmd("int_held",    1, src_a, 32'h8, 32'h0, 32'h0000_1111, 2, 0, 1'b0, -1);
    bus.int_i = 1'b0;
    tick(); tick();
    run_cmd("int_again",   5, src_a, 32'h0, 32'h0, 32'h0,         1, 2, 1'b0, 2);
    bus.int_i = 1'b0;
    tick(); tick();

    for (int i = 0; i < 24; i++) begin
      int r, typ;
      r = $urandom_range(0, 9);
      typ = (r < 4) ? 0 : (r < 8) ? 1 : $urandom_range(2, 7);
      run_cmd($sformatf("rnd%0d", i), typ, 5'($urandom()), $urandom(), $urandom(),
              $urandom(), $urandom_range(0, TMO), $urandom_range(0, 4),
              1'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rtsnoc_to_wishbone_master.md
Name: rtsnoc_to_wishbone_master

Overview:
Target-side NoC endpoint that receives RTSNoC command packets (WRITE cmd+data, READ cmd) from a remote Wishbone-to-NoC bridge. It executes each command as a single Wishbone master cycle on a local peripheral and returns read data to the packet originator. It also forwards a local peripheral interrupt as a PKT_INT packet. It sits between a router local port and one Wishbone slave peripheral, directly downstream of the initiator bridge.

Parameters:
WB_ADDR_WIDTH, 6, Wishbone address width; equals the address field width in the command word.
WB_NOC_DATA_WIDTH, 32, data width of the Wishbone bus and the NoC payload.
NOC_LOCAL_ADR, 0, 3-bit local port of this block; used as the origin field.
NOC_X, 0, X coordinate of this block; used as the origin field.
NOC_Y, 0, Y coordinate of this block; used as the origin field.
NOC_LOCAL_ADR_INT, 0, local port that receives interrupt packets.
NOC_X_INT, 0, X coordinate that receives interrupt packets.
NOC_Y_INT, 0, Y coordinate that receives interrupt packets.
SOC_SIZE_X, 1, X coordinate width (log2).
SOC_SIZE_Y, 1, Y coordinate width (log2).
WB_TIMEOUT, 255, maximum number of cycles to wait for wb_ack_i; 8-bit counter.

Ports:
clk_i  in  1  clock; the block runs on this single clock.
rstn_i  in  1  reset; synchronous, active-low.
wb_cyc_o  out  1  Wishbone cycle.
wb_stb_o  out  1  Wishbone strobe.
wb_adr_o  out  WB_ADDR_WIDTH  Wishbone address.
wb_sel_o  out  4  Wishbone byte select; always 4'hF during a cycle.
wb_we_o  out  1  Wishbone write enable.
wb_dat_o  out  WB_NOC_DATA_WIDTH  Wishbone write data.
wb_dat_i  in  WB_NOC_DATA_WIDTH  Wishbone read data.
wb_ack_i  in  1  Wishbone acknowledge.
int_i  in  1  level interrupt from the peripheral.
noc_din_o  out  NOC_BUS_SIZE  TX flit {X_orig,Y_orig,local_orig,X_dst,Y_dst,local_dst,data}; NOC_BUS_SIZE = WB_NOC_DATA_WIDTH + 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6.
noc_wr_o  out  1  TX write pulse.
noc_rd_o  out  1  RX read pulse.
noc_dout_i  in  NOC_BUS_SIZE  RX flit, same field layout as noc_din_o.
noc_wait_i  in  1  router busy; TX not yet accepted.
noc_nd_i  in  1  RX flit available.

Behaviour:
- Reset: one clock; reset is synchronous and active-low. While rstn_i=0:
  - all outputs are 0, including noc_din_o data and header;
  - state goes to IDLE;
  - the pending-interrupt flag, the int_i edge register and the timeout counter clear.
  - Reset mid-transaction drops wb_cyc_o/wb_stb_o on the next edge and discards any partial packet.
- Command word: type = data[31:29] (WRITE=0, READ=1, INT=2, ERR=3, OK=4); address = data[WB_ADDR_WIDTH-1:0].
- RX handshake: a flit is consumed when noc_nd_i=1 in a receiving state.
  - Capture noc_dout_i and pulse noc_rd_o=1 for exactly one cycle.
  - noc_nd_i is ignored in the cycle noc_rd_o=1, which guarantees a one-cycle gap.
- TX handshake:
  - Load noc_din_o and pulse noc_wr_o for one cycle.
  - Then wait while noc_wait_i=1.
  - The flit is accepted in the first cycle after the pulse with noc_wait_i=0.
  - noc_din_o holds its value until accepted.
- Origin header of every TX flit = {NOC_X, NOC_Y, NOC_LOCAL_ADR}.
- State IDLE (receiving; wb_cyc_o=0):
  - pending interrupt has priority: go to TX_INT;
  - else on RX flit, latch the origin fields as the reply destination;
  - type WRITE: latch address, go to WR_DATA;
  - type READ: latch address, go to WB_READ;
  - any other type: drop it, stay in IDLE.
- WR_DATA (receiving): the next RX flit is the write data; latch it and go to WB_WRITE.
- WB_WRITE:
  - drive cyc=stb=we=1, sel=F, adr, dat;
  - on wb_ack_i, deassert all in the same edge and go to IDLE;
  - on timeout, abort to IDLE; no response is sent.
- WB_READ:
  - drive cyc=stb=1, we=0;
  - on wb_ack_i, capture wb_dat_i and go to TX_REPLY;
  - on timeout, the reply payload = {3'b011, 0} (0x6000_0000 at width 32).
- TX_REPLY:
  - send the payload to the latched origin;
  - on accept, go to IDLE.
- TX_INT:
  - send {3'b010, 0} (0x4000_0000) to {NOC_X_INT, NOC_Y_INT, NOC_LOCAL_ADR_INT};
  - on accept, clear the pending flag and go to IDLE.
- Interrupt detect:
  - a rising edge of int_i (registered previous value) sets the pending flag in any state;
  - an edge arriving while already pending is merged;
  - an edge in the same cycle as the clear keeps the flag set.
- Timeout counter:
  - clears on entering WB_WRITE/WB_READ and increments each cycle without ack;
  - timeout = counter reaches WB_TIMEOUT.
  - Ack in the timeout cycle counts as ack.
- Exactly one Wishbone transaction is outstanding at a time. RX flits arriving during WB_*/TX_* stay in the router (noc_rd_o=0).

Test Plan:
- Write: RX flit cmd 0x0000_0005 then data 0xDEAD_BEEF from (X=1,Y=0,L=2); peripheral acks after 3 cycles -> one WB write with adr=5, dat=0xDEADBEEF, sel=F; exactly two noc_rd_o pulses; no TX flit.
- Read: RX cmd 0x2000_000A from (1,0,2); wb_dat_i=0x1234_5678 acked in 2 cycles -> one TX flit with data 0x12345678, dst=(1,0,2), orig=params; noc_wr_o high for one cycle.
- Backpressure: as the Read case, with noc_wait_i=1 for 5 cycles after the TX pulse -> noc_din_o stable throughout; the next RX flit is not consumed until accepted.
- Timeout: READ to a non-acking slave with WB_TIMEOUT=8 -> cyc drops after 8 cycles; reply 0x6000_0000 is sent. The same test with a WRITE -> no TX flit, return to IDLE.
- Interrupt: int_i rises during WB_READ -> the reply is sent first, then 0x4000_0000 to the interrupt target. int_i held high -> only one INT packet. A new edge after the clear -> a second packet.
- Reset/unknown: RX type 0x8000_0000 (OK) -> consumed and dropped. rstn_i=0 during WB_WRITE -> cyc/stb/noc_* all 0 on the next edge; the next command executes normally.
